// File: rtl/mat_cop_pkg.sv
// rtl/mat_cop_pkg.sv - shared widths, opcodes and FSM encodings for the mul/div coprocessor
//
// Purpose : constants used by mat_cop, its datapath step and the pipeline
//           control that decodes the coprocessor state.
// Contents: GPR_BIT / OPC_BIT / ERR_BIT widths, ALO_* opcodes,
//           MCS_* state encodings, opcode classification helpers.
package mat_cop_pkg;

  localparam int GPR_BIT = 32;
  localparam int OPC_BIT = 6;
  localparam int ERR_BIT = 1;

  localparam logic [OPC_BIT-1:0] ALO_ADD  = 6'h00;
  localparam logic [OPC_BIT-1:0] ALO_MUL  = 6'h18;
  localparam logic [OPC_BIT-1:0] ALO_MULI = 6'h19;
  localparam logic [OPC_BIT-1:0] ALO_DVM  = 6'h1a;
  localparam logic [OPC_BIT-1:0] ALO_DVMI = 6'h1b;

  typedef enum logic [1:0] {
    MCS_IDLE = 2'd0,
    MCS_MUL  = 2'd1,
    MCS_DIV  = 2'd2,
    MCS_DONE = 2'd3
  } mcs_e;

  function automatic logic is_cop_op(input logic [OPC_BIT-1:0] op);
    return (op == ALO_MUL) || (op == ALO_MULI) || (op == ALO_DVM) || (op == ALO_DVMI);
  endfunction

  function automatic logic is_div_op(input logic [OPC_BIT-1:0] op);
    return (op == ALO_DVM) || (op == ALO_DVMI);
  endfunction

endpackage

// File: rtl/mat_cop_step.sv
// rtl/mat_cop_step.sv - one combinational iteration of the shift-add multiply / restoring divide
//
// Purpose : given the current accumulator/remainder and operands, produce the
//           next-iteration values.
// Ports   : is_div  - 1 selects divide step, 0 selects multiply step
//           acc     - MUL: upper product half; DIV: partial remainder
//           opa     - MUL: multiplicand;      DIV: divisor
//           opb     - MUL: lower product half (multiplier bits shift out);
//                     DIV: dividend (quotient bits shift in)
//           acc_nxt, opb_nxt - values after this iteration
module mat_cop_step
  import mat_cop_pkg::*;
#(
  parameter int WIDTH = GPR_BIT
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic [WIDTH-1:0] acc_nxt,
  output logic [WIDTH-1:0] opb_nxt
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   part;
  logic [WIDTH-1:0] diff;
  logic             ge;

  always_comb begin
    // MUL: conditional add into the upper half; the carry becomes the new MSB
    // and the sum LSB shifts down into the lower half.
    sum  = {1'b0, acc} + {1'b0, (opb[0] ? opa : {WIDTH{1'b0}})};
    // DIV: {rem, next dividend bit}. When it is >= divisor the difference is
    // smaller than the divisor, so WIDTH bits are enough to hold it.
    part = {acc, opb[WIDTH-1]};
    ge   = (part >= {1'b0, opa});
    diff = part[WIDTH-1:0] - opa;

    if (is_div) begin
      acc_nxt = ge ? diff : part[WIDTH-1:0];
      opb_nxt = {opb[WIDTH-2:0], ge};
    end else begin
      acc_nxt = sum[WIDTH:1];
      opb_nxt = {sum[0], opb[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mat_cop.sv
// rtl/mat_cop.sv - multi-cycle unsigned multiply/divide coprocessor
//
// Purpose : executes MUL/MULI (shift-add) and DVM/DVMI (restoring divide),
//           one bit per clock, stalling the pipeline via busy.
// Ports   : clk, rst_n       - clock, asynchronous active-low reset
//           start, alu_op    - request strobe and opcode
//           rs, rt           - multiplicand/dividend, multiplier/divisor
//           busy, done       - iterating / one-cycle result-valid pulse
//           mat_cop_res      - MUL low word / DVM quotient
//           mat_cop_hi       - MUL high word / DVM remainder
//           div_zero         - last divide had a zero divisor
module mat_cop
  import mat_cop_pkg::*;
#(
  parameter int WIDTH   = GPR_BIT,
  parameter int CNT_BIT = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [OPC_BIT-1:0] alu_op,
  input  logic [WIDTH-1:0]   rs,
  input  logic [WIDTH-1:0]   rt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   mat_cop_res,
  output logic [WIDTH-1:0]   mat_cop_hi,
  output logic [ERR_BIT-1:0] div_zero
);

  mcs_e               state_q, state_d;
  logic [CNT_BIT-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]   opa_q, opa_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [ERR_BIT-1:0] dz_q, dz_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [WIDTH-1:0]   acc_nxt, opb_nxt;
  logic               accept;

  mat_cop_step #(.WIDTH(WIDTH)) u_step (
    .is_div  (state_q == MCS_DIV),
    .acc     (acc_q),
    .opa     (opa_q),
    .opb     (opb_q),
    .acc_nxt (acc_nxt),
    .opb_nxt (opb_nxt)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    acc_d   = acc_q;
    res_d   = res_q;
    hi_d    = hi_q;
    dz_d    = dz_q;
    accept  = start && ((state_q == MCS_IDLE) || (state_q == MCS_DONE)) && is_cop_op(alu_op);

    case (state_q)
      MCS_MUL, MCS_DIV: begin
        acc_d = acc_nxt;
        opb_d = opb_nxt;
        cnt_d = cnt_q + CNT_BIT'(1);
        if (cnt_q == CNT_BIT'(WIDTH - 1)) begin
          state_d = MCS_DONE;
          res_d   = opb_nxt;
          hi_d    = acc_nxt;
        end
      end
      default: begin
        if (state_q == MCS_DONE) state_d = MCS_IDLE;
        if (accept) begin
          cnt_d = '0;
          acc_d = '0;
          dz_d  = '0;
          if (is_div_op(alu_op)) begin
            opa_d = rt;
            opb_d = rs;
            if (rt == '0) begin
              // Zero divisor short-circuits straight to a result.
              state_d = MCS_DONE;
              res_d   = '1;
              hi_d    = rs;
              dz_d    = ERR_BIT'(1);
            end else begin
              state_d = MCS_DIV;
            end
          end else begin
            opa_d   = rs;
            opb_d   = rt;
            state_d = MCS_MUL;
          end
        end
      end
    endcase

    busy_d = (state_d == MCS_MUL) || (state_d == MCS_DIV);
    done_d = (state_d == MCS_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MCS_IDLE;
      cnt_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      hi_q    <= '0;
      dz_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      hi_q    <= hi_d;
      dz_q    <= dz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign mat_cop_res = res_q;
  assign mat_cop_hi  = hi_q;
  assign div_zero    = dz_q;

endmodule

// File: tb/tb_mat_cop.sv
// tb/tb_mat_cop.sv - scoreboard bench for the mul/div coprocessor
module tb_mat_cop;
  import mat_cop_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic [OPC_BIT-1:0] alu_op = ALO_ADD;
  logic [31:0]        rs = '0;
  logic [31:0]        rt = '0;
  logic               busy;
  logic               done;
  logic [31:0]        res;
  logic [31:0]        hi;
  logic [ERR_BIT-1:0] div_zero;

  typedef struct packed {
    logic [31:0] res;
    logic [31:0] hi;
    logic        dz;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad = 0;
  int   done_cnt = 0;

  mat_cop #(.WIDTH(32), .CNT_BIT(6)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .alu_op      (alu_op),
    .rs          (rs),
    .rt          (rt),
    .busy        (busy),
    .done        (done),
    .mat_cop_res (res),
    .mat_cop_hi  (hi),
    .div_zero    (div_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Called at a negedge; the request is sampled at the following posedge.
  task automatic issue(input logic [OPC_BIT-1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic push, input logic [31:0] er, input logic [31:0] eh, input logic ed);
    exp_t e;
    alu_op = op;
    rs     = a;
    rt     = b;
    start  = 1'b1;
    if (push) begin
      e.res = er;
      e.hi  = eh;
      e.dz  = ed;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Counts negedges until done is seen; also counts busy cycles on the way.
  task automatic wait_done(output int n, output int bn);
    n  = 0;
    bn = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      n++;
      if (busy) bn++;
      if (done) break;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL wait_done: no done within %0d cycles", n);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT reports a result.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && done) begin
        done_cnt++;
        chk("busy_with_done", 32'(busy), 32'd0);
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got res=%h hi=%h want no done", res, hi);
        end else begin
          e = sb_q.pop_front();
          chk("res", res, e.res);
          chk("hi", hi, e.hi);
          chk("div_zero", 32'(div_zero), 32'(e.dz));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, bn, d0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_res", res, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_dz", 32'(div_zero), 32'd0);

    @(negedge clk);
    issue(ALO_MUL, 32'h0001_0000, 32'h0001_0000, 1'b1, 32'h0, 32'h1, 1'b0);
    wait_done(n, bn);
    chk("mul_latency", n, 33);
    chk("mul_busy_cycles", bn, 32);

    @(negedge clk);
    issue(ALO_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h1, 32'hFFFF_FFFE, 1'b0);
    wait_done(n, bn);

    @(negedge clk);
    issue(ALO_DVMI, 32'd100, 32'd7, 1'b1, 32'd14, 32'd2, 1'b0);
    wait_done(n, bn);
    chk("div_latency", n, 33);
    chk("div_busy_cycles", bn, 32);

    @(negedge clk);
    issue(ALO_DVM, 32'h1234, 32'h0, 1'b1, 32'hFFFF_FFFF, 32'h1234, 1'b1);
    wait_done(n, bn);
    chk("dz_latency", n, 1);
    chk("dz_busy_cycles", bn, 0);

    @(negedge clk);
    chk("dz_held_idle", 32'(div_zero), 32'd1);
    issue(ALO_DVM, 32'd1000, 32'd10, 1'b1, 32'd100, 32'd0, 1'b0);
    chk("dz_clear_on_accept", 32'(div_zero), 32'd0);
    wait_done(n, bn);

    @(negedge clk);
    issue(ALO_MULI, 32'd12345, 32'd678, 1'b1, 32'h007F_B6F6, 32'h0, 1'b0);
    wait_done(n, bn);

    // Second start during MUL is dropped.
    @(negedge clk);
    issue(ALO_MUL, 32'd3, 32'd5, 1'b1, 32'd15, 32'd0, 1'b0);
    repeat (9) @(negedge clk);
    issue(ALO_MUL, 32'd7, 32'd7, 1'b0, 32'd0, 32'd0, 1'b0);
    wait_done(n, bn);
    chk("ignore_latency", n, 24);

    // Non-coprocessor opcode.
    @(negedge clk);
    d0 = done_cnt;
    issue(ALO_ADD, 32'd1, 32'd2, 1'b0, 32'd0, 32'd0, 1'b0);
    bn = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy) bn++;
    end
    chk("add_busy_cycles", bn, 0);
    chk("add_done_count", done_cnt - d0, 0);

    // Reset mid-divide.
    @(negedge clk);
    d0 = done_cnt;
    issue(ALO_DVM, 32'h0000_FFFF, 32'd3, 1'b0, 32'd0, 32'd0, 1'b0);
    repeat (14) @(negedge clk);
    chk("busy_before_rst", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_res", res, 32'd0);
    chk("midrst_hi", hi, 32'd0);
    chk("midrst_dz", 32'(div_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("midrst_no_done", done_cnt - d0, 0);
    chk("midrst_idle_busy", 32'(busy), 32'd0);

    // Back-to-back: second start driven during the DONE cycle.
    @(negedge clk);
    issue(ALO_MUL, 32'd6, 32'd7, 1'b1, 32'd42, 32'd0, 1'b0);
    wait_done(n, bn);
    issue(ALO_DVM, 32'hDEAD_BEEF, 32'h10, 1'b1, 32'h0DEA_DBEE, 32'hF, 1'b0);
    wait_done(n, bn);
    chk("b2b_done_gap", n, 33);
    chk("b2b_busy_cycles", bn, 32);

    repeat (3) @(negedge clk);
    chk("sb_empty", sb_q.size(), 0);
    chk("done_total", done_cnt, 9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mat_cop.md
# mat_cop

Multi-cycle integer multiply/divide coprocessor that produces the `mat_cop_res` operand consumed by the execute-stage ALU for `ALO_MUL`, `ALO_MULI`, `ALO_DVM` and `ALO_DVMI`. It accepts a request from the decode/execute boundary and iterates one bit per clock. Results are unsigned 32-bit. It raises `busy` so the pipeline control stalls, then pulses `done` and holds the result until the next accepted request.

## Interface
- `WIDTH`, default `` `GPR_BIT `` (32): operand/result width.
- `CNT_BIT`, default 6: iteration counter width; must hold the value `WIDTH`.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `start` in 1: request strobe, sampled at the rising edge.
- `alu_op` in `` `OPC_BIT ``: opcode. Only `ALO_MUL`, `ALO_MULI`, `ALO_DVM` and `ALO_DVMI` start work.
- `rs` in WIDTH: multiplicand / dividend.
- `rt` in WIDTH: multiplier / divisor. For the I-forms, `rt` is the already-extended immediate.
- `busy` out 1: iteration in progress.
- `done` out 1: one-cycle pulse; result valid.
- `mat_cop_res` out WIDTH: MUL = low product word; DVM = quotient.
- `mat_cop_hi` out WIDTH: MUL = high product word; DVM = remainder.
- `div_zero` out `` `ERR_BIT ``: divisor was zero on the last DVM/DVMI.

## Operation
- FSM states: IDLE, MUL, DIV, DONE.
- **Accept.** A request is accepted when `start`=1 and the state is IDLE or DONE. The opcode must be one of the four listed; any other opcode is ignored and the state is unchanged.
  - `start` during MUL/DIV is ignored. No queueing.
- **Load on accept.**
  - Operands are registered.
  - `cnt` is set to 0.
  - `div_zero` is cleared, except when the zero-divisor case below applies.
  - Accumulator/remainder is set to 0.
- **MUL (shift-add).** Per cycle:
  - If the multiplier LSB is 1, add the multiplicand to the upper half of the 2·WIDTH accumulator.
  - Shift right by one, keeping the carry.
  - After WIDTH iterations, go to DONE.
- **DIV (restoring).** Per cycle:
  - Form `{rem, dividend_msb}`.
  - If it is ≥ divisor, subtract and shift in quotient bit 1; otherwise keep it and shift in 0.
  - After WIDTH iterations, go to DONE.
- **Divisor = 0.** Handled without iterating: go straight to DONE with quotient = all ones, remainder = `rs`, `div_zero`=1.
- **DONE.**
  - `done`=1 for exactly one cycle.
  - The result outputs hold their value until the next accepted request finishes.
  - Without a new `start`, the next state is IDLE.
- **Results.**
  - `mat_cop_res` and `mat_cop_hi` change only on entry to DONE. They never show partial values.
  - `div_zero` changes only on accept (cleared) or on entry to DONE.
- **Reset** (at any time, including mid-iteration):
  - State goes to IDLE.
  - `busy`=0, `done`=0, `mat_cop_res`=0, `mat_cop_hi`=0, `div_zero`=0.
  - Internal registers are cleared.
  - The aborted operation produces no `done`.

## Timing
- Let E0 be the edge at which `start` is accepted.
- **Normal MUL/DIV.**
  - `busy`=1 from after E0 to after E32: 32 cycles.
  - State is DONE after E32; `done`=1 in the cycle between E32 and E33.
  - Latency from `start` to result: 33 cycles.
- **Zero divisor.** `done`=1 in the cycle between E0 and E1. `busy` stays 0.
- **Back-to-back.** `start` sampled at E33 while in DONE is accepted, so `busy` rises immediately after the `done` cycle.
- **`busy` and `done`.** These are registered outputs decoded from the state and are never high together.
- **Counter.** `cnt` counts 0..WIDTH-1. The transition out of MUL/DIV happens on the edge where `cnt`=WIDTH-1.

## Structure
- `ALO_*` opcodes, `GPR_BIT`, `OPC_BIT` and `ERR_BIT` come from the shared `global_macro.v`.
- FSM state encodings are added there as `MCS_IDLE`, `MCS_MUL`, `MCS_DIV` and `MCS_DONE`, so that pipeline-control and debug logic can decode them.
- One sub-module: `mat_cop_step`. It is purely combinational and computes one iteration from the current accumulator/remainder and the operands:
  - the add-shift step for MUL;
  - the compare-subtract-shift step for DIV.
- `mat_cop` holds the FSM, the counter and all registers.

## Test plan
- **MUL.** `rs`=0x0001_0000, `rt`=0x0001_0000 → after 33 cycles `done`=1, `mat_cop_res`=0x0000_0000, `mat_cop_hi`=0x0000_0001. `busy` is high for exactly 32 cycles.
- **MUL, full range.** `rs`=0xFFFF_FFFF, `rt`=0xFFFF_FFFF → `mat_cop_hi`=0xFFFF_FFFE, `mat_cop_res`=0x0000_0001.
- **DVMI.** `rs`=100, `rt`=7 → `mat_cop_res`=14, `mat_cop_hi`=2, `div_zero`=0.
- **Zero divisor.** DVM with `rs`=0x1234, `rt`=0 → `done` in the cycle after accept, `mat_cop_res`=0xFFFF_FFFF, `mat_cop_hi`=0x1234, `div_zero`=1. The next valid DVM clears `div_zero` at accept.
- **Busy and non-coprocessor opcodes.**
  - A second `start` at cycle 10 of a MUL is ignored: the result equals the first operation only.
  - `start` with `ALO_ADD` in IDLE → no `busy` and no `done`.
- **Reset and back-to-back.**
  - `rst_n` low at cycle 15 of a DIV → all outputs 0 immediately, no `done`.
  - Back-to-back MUL then DVM with `start` in the DONE cycle → the second `done` comes exactly 33 cycles after the first.
